// File: rtl/cache_control4way_if.sv
// CPU / physical-memory / datapath-control bundle for the 4-way cache controller.
// slave: seen from the controller; master: seen from the CPU plus datapath side.
interface cache_control4way_if;
  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;
  logic [3:0] hit;
  logic [3:0] valid;
  logic [3:0] dirty;
  logic [1:0] lru;
  logic [3:0] data_writeline;
  logic [3:0] tag_write;
  logic [3:0] valid_write;
  logic [3:0] dirty_write;
  logic       valid_in;
  logic       dirty_in;
  logic       wb_sel;
  logic       update_lru;
  logic [2:0] adrmux_sel;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport slave (
    input  mem_read, mem_write, pmem_resp, hit, valid, dirty, lru,
    output mem_resp, pmem_read, pmem_write, data_writeline, tag_write,
           valid_write, dirty_write, valid_in, dirty_in, wb_sel,
           update_lru, adrmux_sel, hit_count, miss_count
  );

  modport master (
    output mem_read, mem_write, pmem_resp, hit, valid, dirty, lru,
    input  mem_resp, pmem_read, pmem_write, data_writeline, tag_write,
           valid_write, dirty_write, valid_in, dirty_in, wb_sel,
           update_lru, adrmux_sel, hit_count, miss_count
  );
endinterface

// File: rtl/cache_control4way.sv
// 4-way set-associative cache controller: hit service, dirty writeback, line fill.
// Latency: hit completes same cycle; miss = optional WRITEBACK + FETCH, then hit in IDLE.
// Backpressure: CPU request held until mem_resp; pmem states wait on pmem_resp.
module cache_control4way (
  input  logic                  clk,
  input  logic                  rst,
  cache_control4way_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  victim_q, victim_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  logic [1:0]  hit_way;
  logic [1:0]  inv_way;
  logic        any_inv;
  logic [1:0]  pick_way;
  logic        req;

  assign req = bus.mem_read | bus.mem_write;

  // Lowest-index set hit bit and lowest-index invalid way (scan high to low so low wins).
  always_comb begin
    hit_way = 2'd0;
    inv_way = 2'd0;
    any_inv = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.hit[i]) hit_way = 2'(i);
      if (!bus.valid[i]) begin
        inv_way = 2'(i);
        any_inv = 1'b1;
      end
    end
    pick_way = any_inv ? inv_way : bus.lru;
  end

  // Next state, victim capture, counters and all combinational outputs; rst forces everything low.
  always_comb begin
    state_d            = state_q;
    victim_d           = victim_q;
    hit_cnt_d          = hit_cnt_q;
    miss_cnt_d         = miss_cnt_q;
    bus.mem_resp       = 1'b0;
    bus.pmem_read      = 1'b0;
    bus.pmem_write     = 1'b0;
    bus.data_writeline = 4'b0000;
    bus.tag_write      = 4'b0000;
    bus.valid_write    = 4'b0000;
    bus.dirty_write    = 4'b0000;
    bus.valid_in       = 1'b0;
    bus.dirty_in       = 1'b0;
    bus.wb_sel         = 1'b0;
    bus.update_lru     = 1'b0;
    bus.adrmux_sel     = 3'd0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          // pmem_resp deliberately ignored here.
          if (req) begin
            if (|bus.hit) begin
              bus.mem_resp   = 1'b1;
              bus.update_lru = 1'b1;
              // Read+write together is serviced as a write.
              if (bus.mem_write) begin
                bus.data_writeline = 4'b0001 << hit_way;
                bus.dirty_write    = 4'b0001 << hit_way;
                bus.dirty_in       = 1'b1;
                bus.wb_sel         = 1'b1;
              end
              hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
            end else begin
              victim_d   = pick_way;
              state_d    = (bus.valid[pick_way] & bus.dirty[pick_way]) ? WRITEBACK : FETCH;
              miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write = 1'b1;
          bus.adrmux_sel = {1'b0, victim_q} + 3'd1;
          if (bus.pmem_resp) state_d = FETCH;
        end
        FETCH: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.data_writeline = 4'b0001 << victim_q;
            bus.tag_write      = 4'b0001 << victim_q;
            bus.valid_write    = 4'b0001 << victim_q;
            bus.dirty_write    = 4'b0001 << victim_q;
            bus.valid_in       = 1'b1;
            bus.dirty_in       = 1'b0;
            bus.wb_sel         = 1'b0;
            // Request (if still held) is re-evaluated as a hit next cycle.
            state_d            = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, victim and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      victim_q   <= 2'd0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_control4way.sv
// Directed bench for cache_control4way: per-cycle expected output vectors queued and checked.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_cache_control4way;

  logic clk;
  logic rst;
  cache_control4way_if bus ();

  cache_control4way dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [25:0] exp_q [$];
  logic [25:0] obs_vec;

  assign obs_vec = {bus.mem_resp, bus.pmem_read, bus.pmem_write,
                    bus.data_writeline, bus.tag_write, bus.valid_write, bus.dirty_write,
                    bus.valid_in, bus.dirty_in, bus.wb_sel, bus.update_lru, bus.adrmux_sel};

  function automatic logic [25:0] mk(input logic resp, input logic pr, input logic pw,
                                     input logic [3:0] dwl, input logic [3:0] tw,
                                     input logic [3:0] vw, input logic [3:0] dw,
                                     input logic vi, input logic di, input logic wb,
                                     input logic ul, input logic [2:0] adr);
    return {resp, pr, pw, dwl, tw, vw, dw, vi, di, wb, ul, adr};
  endfunction

  function automatic logic [25:0] fill(input logic [3:0] oh);
    return mk(1'b0, 1'b1, 1'b0, oh, oh, oh, oh, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: queue the expected outputs, compare at the falling edge, advance.
  task automatic cyc(input string tag, input logic [25:0] e);
    logic [25:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    chk(tag, {6'd0, obs_vec}, {6'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] h,
                       input logic [3:0] v, input logic [3:0] d, input logic [1:0] l,
                       input logic pr);
    bus.mem_read  = r;
    bus.mem_write = w;
    bus.hit       = h;
    bus.valid     = v;
    bus.dirty     = d;
    bus.lru       = l;
    bus.pmem_resp = pr;
  endtask

  localparam logic [25:0] NONE  = 26'd0;
  localparam logic [25:0] RDHIT = 26'b1_0_0_0000_0000_0000_0000_0_0_0_1_000;

  initial begin
    // Reset with a hitting request present: every output must stay low.
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 2'd0, 1'b1);
    @(negedge clk);
    chk("reset_outputs", {6'd0, obs_vec}, 32'd0);
    chk("reset_hit_count", {16'd0, bus.hit_count}, 32'd0);
    chk("reset_miss_count", {16'd0, bus.miss_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle, including a stray pmem_resp.
    drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b1);
    cyc("idle_pmem_resp", NONE);

    // Read hit way 2.
    drive(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("read_hit_w2", RDHIT);
    chk("hit_count_1", {16'd0, bus.hit_count}, 32'd1);

    // Write hit way 1.
    drive(1'b0, 1'b1, 4'b0010, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("write_hit_w1", mk(1, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 0, 1, 1, 1, 3'd0));
    // Two hit bits: lowest index (way 2) wins.
    drive(1'b0, 1'b1, 4'b1100, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("write_hit_lowest", mk(1, 0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 0, 1, 1, 1, 3'd0));
    // Read and write together act as a write.
    drive(1'b1, 1'b1, 4'b1000, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("rw_as_write", mk(1, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 1, 1, 1, 3'd0));
    chk("hit_count_4", {16'd0, bus.hit_count}, 32'd4);

    // Read miss with dirty LRU victim way 2: writeback then fetch.
    drive(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0100, 2'd2, 1'b0);
    cyc("miss_dirty", NONE);
    chk("miss_count_1", {16'd0, bus.miss_count}, 32'd1);
    // Victim must stay way 2 even though lru/valid/dirty change now.
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("writeback_wait", mk(0, 0, 1, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 0, 3'd3));
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1);
    cyc("writeback_resp", mk(0, 0, 1, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 0, 3'd3));
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    cyc("fetch_wait", mk(0, 1, 0, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 0, 3'd0));
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1);
    cyc("fetch_fill_w2", fill(4'b0100));
    drive(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0100, 2'd1, 1'b0);
    cyc("refill_hit", RDHIT);
    chk("hit_count_5", {16'd0, bus.hit_count}, 32'd5);
    chk("miss_count_still_1", {16'd0, bus.miss_count}, 32'd1);

    // Miss with an invalid way 2: straight to fetch, no writeback; request dropped mid-fetch.
    drive(1'b1, 1'b0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 1'b0);
    cyc("miss_invalid", NONE);
    drive(1'b0, 1'b0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 1'b0);
    cyc("fetch_no_wb", mk(0, 1, 0, 4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 0, 3'd0));
    drive(1'b0, 1'b0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 1'b1);
    cyc("fill_dropped_req", fill(4'b0100));
    drive(1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1111, 2'd0, 1'b1);
    cyc("idle_after_drop", NONE);

    // All valid and clean: LRU way 3 chosen, fetch, then write hit.
    drive(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0);
    cyc("miss_lru3", NONE);
    drive(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b1);
    cyc("fill_w3", fill(4'b1000));
    drive(1'b0, 1'b1, 4'b1000, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("write_hit_w3", mk(1, 0, 0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 1, 1, 1, 3'd0));
    chk("hit_count_6", {16'd0, bus.hit_count}, 32'd6);
    chk("miss_count_3", {16'd0, bus.miss_count}, 32'd3);

    // Reset pulsed mid-fetch.
    drive(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc("miss_before_rst", NONE);
    @(negedge clk);
    chk("fetch_before_rst", {31'd0, bus.pmem_read}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", {6'd0, obs_vec}, 32'd0);
    chk("rst_hit_count", {16'd0, bus.hit_count}, 32'd0);
    chk("rst_miss_count", {16'd0, bus.miss_count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 4'b0001, 4'b1111, 4'b0000, 2'd0, 1'b0);
    cyc("post_rst_hit", RDHIT);
    chk("post_rst_hit_count", {16'd0, bus.hit_count}, 32'd1);

    // Saturate hit_count: request held hitting for 65534 more edges.
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    chk("hit_count_max", {16'd0, bus.hit_count}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    chk("hit_count_saturated", {16'd0, bus.hit_count}, 32'h0000FFFF);
    chk("miss_count_after_sat", {16'd0, bus.miss_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
